vga_rx_monitor: RTL
===================

Name: vga_rx_monitor

Overview:
- Receiving end of the game's VGA pixel stream: consumes the same HS/VS/BLANK_N and 1-bit R/G/B signals that drive the DAC.
- Reconstructs pixel coordinates from sync/blank, checks 640x480 frame geometry and tracks lock.
- Extracts the ball position (topmost-leftmost white pixel) once per frame and flags ball-on-ground events.
- Used in-system by scoring logic and on the bench as a checker for the display path.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- GROUND_Y, 450, first active line counted as ground
- LOCK_FRAMES, 2, consecutive good frames needed to assert locked

Ports:
- clk  in  1  pixel clock (VGA_CLK domain)
- rst  in  1  asynchronous, active-low reset
- hs  in  1  horizontal sync, active-low
- vs  in  1  vertical sync, active-low
- blank_n  in  1  high during active video
- r, g, b  in  1 each  pixel colour bits
- pix_valid  out  1  registered copy of blank_n
- x_pos  out  10  column of current pixel, valid with pix_valid
- y_pos  out  10  row of current pixel, valid with pix_valid
- locked  out  1  geometry stable for LOCK_FRAMES frames
- frame_done  out  1  one-cycle pulse on each vs falling edge after SEEK
- ball_found  out  1  white pixel seen in last completed frame
- ball_x  out  10  column of first white pixel, last completed frame
- ball_y  out  10  row of first white pixel, last completed frame
- ball_landed  out  1  one-cycle pulse at frame_done if any white pixel had y >= GROUND_Y
- line_err  out  1  sticky; cleared only by reset
- frame_err  out  1  sticky; cleared only by reset

Behaviour:
- Reset (rst=0, async): all outputs 0; counters 0; state SEEK.
- Inputs registered once. Edge detects use the registered copy vs. the previous registered copy.
- Latency: pix_valid/x_pos/y_pos lag the input pixel by exactly 1 clk.
- x counter:
  - Cleared on blank_n rising; increments each active cycle.
  - Saturates at 1023.
  - On blank_n falling, if pixel count != H_ACTIVE, set line_err; then y increments.
- y counter:
  - Cleared on vs falling; saturates at 1023.
  - hs is only checked for presence: a line with no hs low pulse between two blank_n rising edges sets line_err.
- States:
  - SEEK: ignore data until first vs falling. Then go to TRACK with good_cnt=0. No frame_done is emitted on this edge.
  - TRACK: on each vs falling, frame_done=1.
    - Frame good (lines == V_ACTIVE and no line error this frame): good_cnt++. At good_cnt == LOCK_FRAMES, go to LOCKED and set locked=1.
    - Frame bad: set frame_err, good_cnt=0.
  - LOCKED: on each vs falling, frame_done=1.
    - Any bad frame: locked=0, set frame_err, go to TRACK with good_cnt=0.
- Ball capture:
  - A white pixel is r&g&b with blank_n=1.
  - The first white pixel in raster order each frame latches candidate x/y.
  - At frame_done: ball_found/ball_x/ball_y update from the candidate (ball_x/ball_y hold old values if none found), then the candidate is cleared.
  - Ball capture runs in TRACK and LOCKED, independent of lock.
- ball_landed: per-frame flag set by any white pixel with y >= GROUND_Y; pulses with frame_done, then clears.
- Boundary cases:
  - vs falls while blank_n=1: the frame boundary is honoured and frame_err is set.
  - White pixel on the same cycle as vs falling: that pixel belongs to the new frame.
  - More than 1023 pixels in a line: count saturates and line_err is set.
  - Reset mid-frame: state returns to SEEK; the partial frame is discarded.

Test Plan:
- Reset, then 3 clean 640x480 frames (800x525 total, active-low syncs) -> frame_done pulses 2 times after first vs; locked=1 one clk after third vs fall (LOCK_FRAMES=2); no errors.
- Single white pixel at (100,200) in frame N -> after frame N's end: ball_found=1, ball_x=100, ball_y=200, ball_landed=0.
- White pixels at (300,455) and (310,460) -> ball_x=300, ball_y=455, ball_landed pulse of exactly 1 clk.
- Locked stream, one line with 639 active pixels -> line_err=1 (sticky), locked=0 at next vs fall, re-locks after 2 good frames.
- Frame of 479 lines -> frame_err=1, locked stays 0. Assert rst=0 mid-frame -> all outputs 0 asynchronously; no frame_done until second vs fall after release.
- Check pix_valid/x_pos/y_pos against input blank_n and a reference counter -> exact 1-clk lag; x_pos 0..639 each line.

Source files
------------

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: watches the VGA pixel stream that feeds the DAC, rebuilds
// pixel coordinates from sync/blank, checks frame geometry, tracks lock and
// extracts the ball (first white pixel in raster order) once per frame.
module vga_rx_monitor #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int GROUND_Y    = 450,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs,
  input  logic       vs,
  input  logic       blank_n,
  input  logic       r,
  input  logic       g,
  input  logic       b,
  output logic       pix_valid,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       locked,
  output logic       frame_done,
  output logic       ball_found,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_landed,
  output logic       line_err,
  output logic       frame_err
);

  typedef enum logic [1:0] {SEEK, TRACK, LOCKED} state_t;

  localparam logic [9:0] C_H_ACTIVE = 10'(H_ACTIVE);
  localparam logic [9:0] C_V_ACTIVE = 10'(V_ACTIVE);
  localparam logic [9:0] C_GROUND_Y = 10'(GROUND_Y);
  localparam logic [9:0] C_MAX      = 10'd1023;
  localparam logic [7:0] C_LOCK     = 8'(LOCK_FRAMES);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_good_cnt;
  logic [7:0] w_next_good;
  logic [7:0] w_good_inc;

  logic       r_hs, r_vs, r_blank, r_r, r_g, r_b;
  logic       r_vs_d, r_blank_d;
  logic [9:0] r_x_cnt, r_y_cnt;
  logic       r_seen_rise, r_hs_seen, r_frame_line_bad;
  logic       r_line_err, r_frame_err;
  logic       r_cand_valid, r_land;
  logic [9:0] r_cand_x, r_cand_y;
  logic       r_ball_found;
  logic [9:0] r_ball_x, r_ball_y;

  logic       w_vs_fall, w_blank_rise, w_blank_fall, w_white;
  logic [9:0] w_x_cur, w_y_cur;
  logic       w_tracking, w_line_evt, w_frame_good;
  logic       w_frame_done, w_frame_bad;

  // Single input register stage plus the previous copy used for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hs      <= 1'b0;
      r_vs      <= 1'b0;
      r_blank   <= 1'b0;
      r_r       <= 1'b0;
      r_g       <= 1'b0;
      r_b       <= 1'b0;
      r_vs_d    <= 1'b0;
      r_blank_d <= 1'b0;
    end else begin
      r_hs      <= hs;
      r_vs      <= vs;
      r_blank   <= blank_n;
      r_r       <= r;
      r_g       <= g;
      r_b       <= b;
      r_vs_d    <= r_vs;
      r_blank_d <= r_blank;
    end
  end

  // Edge detects and the coordinates of the pixel currently in the input stage;
  // a pixel coinciding with a vs fall is already row 0 of the new frame
  always_comb begin
    w_vs_fall    = r_vs_d & ~r_vs;
    w_blank_rise = r_blank & ~r_blank_d;
    w_blank_fall = r_blank_d & ~r_blank;
    w_white      = r_blank & r_r & r_g & r_b;
    w_x_cur      = w_blank_rise ? 10'd0 : r_x_cnt;
    w_y_cur      = w_vs_fall ? 10'd0 : r_y_cnt;
    w_tracking   = (r_state != SEEK);
    w_line_evt   = (w_blank_fall && (r_x_cnt != C_H_ACTIVE)) ||
                   (w_blank_rise && r_seen_rise && !r_hs_seen);
    w_frame_good = (r_y_cnt == C_V_ACTIVE) && !r_frame_line_bad &&
                   !w_line_evt && !r_blank;
    w_good_inc   = r_good_cnt + 8'd1;
  end

  // Pixel and line counters, both saturating at 1023
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x_cnt <= 10'd0;
      r_y_cnt <= 10'd0;
    end else begin
      if (r_blank)
        r_x_cnt <= (w_x_cur == C_MAX) ? C_MAX : w_x_cur + 10'd1;
      if (w_vs_fall)
        r_y_cnt <= 10'd0;
      else if (w_blank_fall && (r_y_cnt != C_MAX))
        r_y_cnt <= r_y_cnt + 10'd1;
    end
  end

  // Line checks: hs presence between blank rises and per-frame line error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seen_rise      <= 1'b0;
      r_hs_seen        <= 1'b0;
      r_frame_line_bad <= 1'b0;
    end else begin
      if (w_blank_rise) begin
        r_seen_rise <= 1'b1;
        r_hs_seen   <= 1'b0;
      end else if (!r_hs) begin
        r_hs_seen <= 1'b1;
      end
      if (w_vs_fall)
        r_frame_line_bad <= 1'b0;
      else if (w_line_evt)
        r_frame_line_bad <= 1'b1;
    end
  end

  // Lock state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= SEEK;
      r_good_cnt <= 8'd0;
    end else begin
      r_state    <= w_next_state;
      r_good_cnt <= w_next_good;
    end
  end

  // Lock next-state logic, judged once per frame at the vs falling edge
  always_comb begin
    w_next_state = r_state;
    w_next_good  = r_good_cnt;
    w_frame_done = 1'b0;
    w_frame_bad  = 1'b0;
    case (r_state)
      SEEK: begin
        if (w_vs_fall) begin
          w_next_state = TRACK;
          w_next_good  = 8'd0;
        end
      end
      TRACK: begin
        if (w_vs_fall) begin
          w_frame_done = 1'b1;
          if (w_frame_good) begin
            w_next_good = w_good_inc;
            if (w_good_inc >= C_LOCK)
              w_next_state = LOCKED;
          end else begin
            w_frame_bad = 1'b1;
            w_next_good = 8'd0;
          end
        end
      end
      LOCKED: begin
        if (w_vs_fall) begin
          w_frame_done = 1'b1;
          if (!w_frame_good) begin
            w_frame_bad  = 1'b1;
            w_next_state = TRACK;
            w_next_good  = 8'd0;
          end
        end
      end
      default: begin
        w_next_state = SEEK;
        w_next_good  = 8'd0;
      end
    endcase
  end

  // Sticky error flags, only raised once the stream is being tracked
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line_err  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_tracking && w_line_evt)
        r_line_err <= 1'b1;
      if (w_frame_bad)
        r_frame_err <= 1'b1;
    end
  end

  // Per-frame ball candidate and ground flag, restarted at every vs fall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cand_valid <= 1'b0;
      r_cand_x     <= 10'd0;
      r_cand_y     <= 10'd0;
      r_land       <= 1'b0;
    end else if (w_vs_fall) begin
      r_cand_valid <= w_white;
      r_cand_x     <= w_white ? w_x_cur : 10'd0;
      r_cand_y     <= w_white ? w_y_cur : 10'd0;
      r_land       <= w_white && (w_y_cur >= C_GROUND_Y);
    end else begin
      if (w_white && !r_cand_valid) begin
        r_cand_valid <= 1'b1;
        r_cand_x     <= w_x_cur;
        r_cand_y     <= w_y_cur;
      end
      if (w_white && (w_y_cur >= C_GROUND_Y))
        r_land <= 1'b1;
    end
  end

  // Publish the completed frame's ball result; position holds if none found
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ball_found <= 1'b0;
      r_ball_x     <= 10'd0;
      r_ball_y     <= 10'd0;
    end else if (w_frame_done) begin
      r_ball_found <= r_cand_valid;
      if (r_cand_valid) begin
        r_ball_x <= r_cand_x;
        r_ball_y <= r_cand_y;
      end
    end
  end

  assign pix_valid   = r_blank;
  assign x_pos       = w_x_cur;
  assign y_pos       = w_y_cur;
  assign locked      = (r_state == LOCKED);
  assign frame_done  = w_frame_done;
  assign ball_landed = w_frame_done & r_land;
  assign ball_found  = r_ball_found;
  assign ball_x      = r_ball_x;
  assign ball_y      = r_ball_y;
  assign line_err    = r_line_err;
  assign frame_err   = r_frame_err;

endmodule
